// File: rtl/spi_prefetch_fetch_if.sv
// CPU-side fetch bus of the SPI prefetch unit: redirect request, head-of-FIFO
// instruction handshake and occupancy.
interface spi_prefetch_fetch_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
);
    localparam int FILL_W = $clog2(DEPTH) + 1;

    logic               redirect;
    logic [ADDR_W-1:0]  redirect_addr;
    logic               instr_ready;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_addr;
    logic [FILL_W-1:0]  fill_level;

    // master: the CPU (program counter / control unit)
    modport master (
        output redirect, redirect_addr, instr_ready,
        input  instr_valid, instr, instr_addr, fill_level
    );

    // slave: the fetch unit
    modport slave (
        input  redirect, redirect_addr, instr_ready,
        output instr_valid, instr, instr_addr, fill_level
    );
endinterface

// File: rtl/spi_prefetch_fetch.sv
// Streaming SPI SRAM instruction fetcher: one READ command per address stream,
// sequential words shifted into a prefetch FIFO, flushed and restarted on redirect.
module spi_prefetch_fetch #(
    parameter int                ADDR_W     = 16,
    parameter int                INSTR_W    = 16,
    parameter int                SPI_ADDR_W = 24,
    parameter int                DEPTH      = 4,
    parameter int                CS_GAP     = 1,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_prefetch_fetch_if.slave  bus,
    output logic                 spi_cs,
    output logic                 spi_sck,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);
    typedef enum logic [2:0] {GAP, CMD, ADDR, DATA, PAUSE} state_t;

    localparam int         PTR_W    = $clog2(DEPTH);
    localparam int         FILL_W   = PTR_W + 1;
    localparam int         TX_W     = 8 + SPI_ADDR_W;
    localparam int         CNT_W    = $clog2(TX_W + INSTR_W);
    localparam int         GAP_W    = $clog2(CS_GAP + 1);
    localparam logic [7:0] READ_CMD = 8'h03;

    state_t             state_q, state_d;
    logic               boot_q;
    logic               phase_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [TX_W-1:0]    tx_q;
    logic [INSTR_W-2:0] rx_q;
    logic [ADDR_W-1:0]  fetch_addr_q;
    logic [INSTR_W-1:0] mem_data [DEPTH];
    logic [ADDR_W-1:0]  mem_addr [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FILL_W-1:0]  fill_q;

    logic               flush, shifting, bit_end, last_bit, gap_done;
    logic               push, pop, fifo_valid;
    logic [INSTR_W-1:0] word_in;
    logic [FILL_W-1:0]  fill_after;

    // The first cycle out of reset is treated exactly like a redirect.
    assign flush      = boot_q | bus.redirect;
    assign shifting   = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
    assign bit_end    = shifting & phase_q;
    assign gap_done   = (gap_cnt_q == GAP_W'(CS_GAP - 1));
    assign word_in    = {rx_q, spi_miso};
    assign fifo_valid = (fill_q != '0);
    assign push       = (state_q == DATA) & bit_end & last_bit & ~flush;
    assign pop        = fifo_valid & bus.instr_ready & ~flush;
    assign fill_after = fill_q + FILL_W'(push) - FILL_W'(pop);

    always_comb begin
        last_bit = 1'b0;
        case (state_q)
            CMD:     last_bit = (bit_cnt_q == CNT_W'(7));
            ADDR:    last_bit = (bit_cnt_q == CNT_W'(SPI_ADDR_W - 1));
            DATA:    last_bit = (bit_cnt_q == CNT_W'(INSTR_W - 1));
            default: last_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= GAP;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = GAP;
        end else begin
            case (state_q)
                GAP:     if (gap_done) state_d = CMD;
                CMD:     if (bit_end && last_bit) state_d = ADDR;
                ADDR:    if (bit_end && last_bit) state_d = DATA;
                // Stop before the next word if it could not be accepted.
                DATA:    if (push && (fill_after == FILL_W'(DEPTH))) state_d = PAUSE;
                PAUSE:   if (fill_q != FILL_W'(DEPTH)) state_d = DATA;
                default: state_d = GAP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            boot_q       <= 1'b1;
            phase_q      <= 1'b0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            fetch_addr_q <= RESET_ADDR;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
        end else begin
            boot_q <= 1'b0;
            if (flush) begin
                phase_q      <= 1'b0;
                bit_cnt_q    <= '0;
                gap_cnt_q    <= '0;
                fetch_addr_q <= bus.redirect ? bus.redirect_addr : RESET_ADDR;
                wr_ptr_q     <= '0;
                rd_ptr_q     <= '0;
                fill_q       <= '0;
            end else begin
                if (state_q == GAP)
                    gap_cnt_q <= gap_done ? '0 : gap_cnt_q + 1'b1;
                if (shifting)
                    phase_q <= ~phase_q;
                if (bit_end)
                    bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
                if (push) begin
                    fetch_addr_q <= fetch_addr_q + 1'b1;
                    wr_ptr_q     <= wr_ptr_q + 1'b1;
                end
                if (pop)
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                fill_q <= fill_after;
            end
        end
    end

    // Shift registers and FIFO storage carry no reset; outputs are qualified by state/fill.
    always_ff @(posedge clk) begin
        if (state_q == GAP)
            tx_q <= {READ_CMD, SPI_ADDR_W'({fetch_addr_q, 1'b0})};
        else if (bit_end)
            tx_q <= tx_q << 1;
        if (bit_end && (state_q == DATA))
            rx_q <= word_in[INSTR_W-2:0];
        if (push) begin
            mem_data[wr_ptr_q] <= word_in;
            mem_addr[wr_ptr_q] <= fetch_addr_q;
        end
    end

    assign spi_cs   = (state_q == GAP);
    assign spi_sck  = shifting & phase_q;
    assign spi_mosi = ((state_q == CMD) || (state_q == ADDR)) & tx_q[TX_W-1];

    assign bus.instr_valid = fifo_valid;
    assign bus.instr       = fifo_valid ? mem_data[rd_ptr_q] : '0;
    assign bus.instr_addr  = fifo_valid ? mem_addr[rd_ptr_q] : '0;
    assign bus.fill_level  = fill_q;
endmodule

// File: tb/tb_spi_prefetch_fetch.sv
// Bench for spi_prefetch_fetch: SPI SRAM slave model plus a word-level
// expected-address model, directed scenarios followed by randomized traffic.
module tb_spi_prefetch_fetch;
    localparam int ADDR_W     = 16;
    localparam int INSTR_W    = 16;
    localparam int SPI_ADDR_W = 24;
    localparam int DEPTH      = 4;
    localparam int CS_GAP     = 1;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic spi_miso = 1'b0;
    logic spi_cs, spi_sck, spi_mosi;

    int compared   = 0;
    int mismatched = 0;
    int pops       = 0;

    logic [ADDR_W-1:0] exp_addr    = '0;
    logic [ADDR_W-1:0] stream_addr = '0;

    spi_prefetch_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus ();

    spi_prefetch_fetch #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .SPI_ADDR_W(SPI_ADDR_W),
        .DEPTH(DEPTH), .CS_GAP(CS_GAP), .RESET_ADDR(16'h0000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] sram(input logic [ADDR_W-1:0] a);
        return 16'hA000 + a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SRAM slave: captures command/address, then streams words MSB first.
    int                nbits = 0;
    logic [31:0]       hdr   = '0;
    logic [ADDR_W-1:0] slave_addr = '0;
    always @(negedge clk) begin
        int                 k;
        logic [ADDR_W-1:0]  w;
        logic [INSTR_W-1:0] word;
        if (spi_cs !== 1'b0) begin
            nbits      = 0;
            spi_miso   = 1'b0;
            slave_addr = stream_addr;
        end else if (spi_sck === 1'b1) begin
            if (nbits < 32) begin
                hdr = {hdr[30:0], spi_mosi};
                if (nbits == 31) begin
                    check("spi_cmd", {24'd0, hdr[31:24]}, 32'h03);
                    check("spi_addr", {8'd0, hdr[23:0]}, {15'd0, slave_addr, 1'b0});
                end
            end else begin
                k        = nbits - 32;
                w        = hdr[16:1] + ADDR_W'(k / INSTR_W);
                word     = sram(w);
                spi_miso = word[INSTR_W - 1 - (k % INSTR_W)];
            end
            nbits++;
        end
    end

    // One clock: account for what the coming edge does, then observe at the falling edge.
    task automatic clk_step();
        if (!rst_n) begin
            exp_addr    = '0;
            stream_addr = '0;
        end else if (bus.redirect) begin
            exp_addr    = bus.redirect_addr;
            stream_addr = bus.redirect_addr;
        end else if (bus.instr_valid && bus.instr_ready) begin
            check("pop_addr", {16'd0, bus.instr_addr}, {16'd0, exp_addr});
            check("pop_instr", {16'd0, bus.instr}, {16'd0, sram(exp_addr)});
            exp_addr = exp_addr + 1'b1;
            pops++;
        end
        @(negedge clk);
        check("fill_le_depth", {31'd0, bus.fill_level <= 3'(DEPTH)}, 32'd1);
        check("valid_vs_fill", {31'd0, bus.instr_valid}, {31'd0, bus.fill_level != '0});
    endtask

    task automatic wait_valid(output int edges, input int limit);
        edges = 0;
        while (!bus.instr_valid && edges < limit) begin
            clk_step();
            edges++;
        end
    endtask

    task automatic wait_fill(input int target, input int limit);
        int n = 0;
        while (int'(bus.fill_level) != target && n < limit) begin
            clk_step();
            n++;
        end
    endtask

    initial begin
        int                n;
        int                quiet_viol;
        int                cs_rises;
        logic              cs_prev;
        logic              saw_low;
        logic [ADDR_W-1:0] hold_addr;

        bus.redirect      = 1'b0;
        bus.redirect_addr = '0;
        bus.instr_ready   = 1'b1;
        rst_n             = 1'b0;
        @(negedge clk);
        clk_step();
        clk_step();
        check("rst_cs", {31'd0, spi_cs}, 32'd1);
        check("rst_sck", {31'd0, spi_sck}, 32'd0);
        check("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_fill", {29'd0, bus.fill_level}, 32'd0);
        check("rst_instr", {16'd0, bus.instr}, 32'd0);
        check("rst_instr_addr", {16'd0, bus.instr_addr}, 32'd0);

        // Release: first live edge acts as a redirect to address 0.
        rst_n = 1'b1;
        clk_step();
        check("gap_cs_high", {31'd0, spi_cs}, 32'd1);
        clk_step();
        check("cmd_cs_low", {31'd0, spi_cs}, 32'd0);
        wait_valid(n, 300);
        check("first_latency", n + 1, 32'd97);
        check("first_instr", {16'd0, bus.instr}, 32'h0000A000);
        check("first_addr", {16'd0, bus.instr_addr}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            clk_step();
            wait_valid(n, 100);
            check("word_period", n + 1, 32'd32);
        end

        // Backpressure fills the FIFO and parks the stream with CS held low.
        bus.instr_ready = 1'b0;
        wait_fill(DEPTH, 400);
        check("fill_full", {29'd0, bus.fill_level}, DEPTH);
        quiet_viol = 0;
        for (int i = 0; i < 40; i++) begin
            clk_step();
            if (spi_sck !== 1'b0 || spi_cs !== 1'b0) quiet_viol++;
        end
        check("pause_quiet", quiet_viol, 32'd0);
        check("pause_fill", {29'd0, bus.fill_level}, DEPTH);
        hold_addr = exp_addr;
        bus.instr_ready = 1'b1;
        clk_step();
        bus.instr_ready = 1'b0;
        check("pop_one_fill", {29'd0, bus.fill_level}, 32'd3);
        wait_fill(DEPTH, 100);
        check("resume_fill", {29'd0, bus.fill_level}, DEPTH);
        check("resume_head", {16'd0, bus.instr_addr}, {16'd0, hold_addr + 16'd1});
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 14; i++) clk_step();

        // Redirect while a word is partly received.
        bus.redirect      = 1'b1;
        bus.redirect_addr = 16'h0100;
        clk_step();
        bus.redirect = 1'b0;
        check("redir_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("redir_cs", {31'd0, spi_cs}, 32'd1);
        check("redir_fill", {29'd0, bus.fill_level}, 32'd0);
        wait_valid(n, 300);
        check("redir_latency", n, 32'd97);
        check("redir_instr", {16'd0, bus.instr}, 32'h0000A100);
        check("redir_addr", {16'd0, bus.instr_addr}, 32'h00000100);

        // Redirect coinciding with a pop on a full FIFO.
        bus.instr_ready = 1'b0;
        wait_fill(DEPTH, 400);
        check("full_before_redir", {29'd0, bus.fill_level}, DEPTH);
        bus.instr_ready   = 1'b1;
        bus.redirect      = 1'b1;
        bus.redirect_addr = ADDR_W'($urandom);
        clk_step();
        bus.redirect = 1'b0;
        check("redir_pop_fill", {29'd0, bus.fill_level}, 32'd0);
        check("redir_pop_valid", {31'd0, bus.instr_valid}, 32'd0);
        wait_valid(n, 300);
        check("redir_pop_latency", n, 32'd97);

        // Address wrap inside one CS assertion.
        bus.redirect      = 1'b1;
        bus.redirect_addr = 16'hFFFE;
        clk_step();
        bus.redirect = 1'b0;
        pops = 0; cs_rises = 0; saw_low = 1'b0; n = 0;
        while (pops < 3 && n < 400) begin
            cs_prev = spi_cs;
            clk_step();
            if (saw_low && spi_cs && !cs_prev) cs_rises++;
            if (!spi_cs) saw_low = 1'b1;
            n++;
        end
        check("wrap_pops", pops, 32'd3);
        check("wrap_cs_rises", cs_rises, 32'd0);
        check("wrap_next_addr", {16'd0, exp_addr}, 32'd1);

        // Reset in the middle of the address phase.
        bus.redirect      = 1'b1;
        bus.redirect_addr = 16'h1234;
        clk_step();
        bus.redirect = 1'b0;
        for (int i = 0; i < 30; i++) clk_step();
        check("in_addr_cs", {31'd0, spi_cs}, 32'd0);
        rst_n = 1'b0;
        clk_step();
        check("midrst_cs", {31'd0, spi_cs}, 32'd1);
        check("midrst_sck", {31'd0, spi_sck}, 32'd0);
        check("midrst_fill", {29'd0, bus.fill_level}, 32'd0);
        rst_n = 1'b1;
        clk_step();
        wait_valid(n, 300);
        check("midrst_latency", n, 32'd97);
        check("midrst_addr", {16'd0, bus.instr_addr}, 32'd0);
        check("midrst_instr", {16'd0, bus.instr}, 32'h0000A000);

        // Randomized ready and occasional redirects.
        pops = 0;
        for (int i = 0; i < 4000; i++) begin
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) begin
                bus.redirect      = 1'b1;
                bus.redirect_addr = ADDR_W'($urandom);
            end
            clk_step();
            bus.redirect = 1'b0;
        end
        check("rand_progress", {31'd0, pops > 20}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/spi_prefetch_fetch.md
Name: spi_prefetch_fetch

Overview:
- Next-generation instruction fetch unit for the CPU. It replaces the single-word SPI RAM program memory with a parametrised, streaming SPI SRAM reader.
- It issues one READ (0x03) command per address stream, then clocks out consecutive instructions in sequential mode into a prefetch FIFO of depth DEPTH.
- The CPU pops one instruction per cycle. The CPU issues a redirect on a branch, which flushes the FIFO and restarts the stream.
- Sits between the SPI pins (uio) and the ProgramCounter/ControlUnit.

Parameters:
- ADDR_W, 16, instruction (word) address width.
- INSTR_W, 16, instruction width in bits; a multiple of 8.
- SPI_ADDR_W, 24, SPI address bits sent after the command; ADDR_W+1 <= SPI_ADDR_W.
- DEPTH, 4, prefetch FIFO entries; a power of two, >= 2.
- CS_GAP, 1, minimum clk cycles spi_cs is held high between streams; >= 1.
- RESET_ADDR, 0, word address fetched after reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- redirect  in  1  one-cycle request to flush and refetch from redirect_addr.
- redirect_addr  in  ADDR_W  new word address.
- instr_ready  in  1  consumer pops the head entry when instr_valid=1.
- instr_valid  out  1  FIFO non-empty.
- instr  out  INSTR_W  head instruction.
- instr_addr  out  ADDR_W  word address of the head instruction.
- fill_level  out  clog2(DEPTH)+1  FIFO occupancy.
- spi_cs  out  1  chip select, active low.
- spi_sck  out  1  SPI clock, mode 0.
- spi_mosi  out  1  serial data to the SRAM.
- spi_miso  in  1  serial data from the SRAM, already synchronised upstream.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-low on rst_n.
- Reset values: spi_cs=1, spi_sck=0, spi_mosi=0, instr_valid=0, fill_level=0, instr=0, instr_addr=0, FSM=GAP.
- After reset: the first edge with rst_n=1 behaves as a redirect to RESET_ADDR.
- SPI bit timing:
  - One bit takes 2 clk cycles.
  - Phase A: spi_sck=0, spi_mosi updated.
  - Phase B: spi_sck=1.
  - spi_miso is sampled on the clk edge that returns spi_sck to 0.
  - All bits are MSB first.
- FSM states: GAP, CMD, ADDR, DATA, PAUSE.
- GAP:
  - spi_cs=1 and spi_sck=0 for CS_GAP cycles.
  - Then go to CMD with spi_cs=0.
- CMD: shift out 8 bits of 0x03, then go to ADDR.
- ADDR:
  - Shift out SPI_ADDR_W bits of {fetch_addr,1'b0}, zero-extended (byte address).
  - Then go to DATA.
- DATA:
  - Shift in INSTR_W bits. The first received bit is instr[INSTR_W-1].
  - On the sampling edge of the last bit, push {word, fetch_addr} into the FIFO and increment fetch_addr modulo 2^ADDR_W.
  - Wrap is not special-cased; the CS stream continues.
- Word boundary:
  - If fill_level==DEPTH (after this cycle's pop is accounted), go to PAUSE.
  - Otherwise start the next word in DATA.
- PAUSE:
  - spi_cs=0 and spi_sck=0 are held; no bits are clocked.
  - Resume DATA on the first cycle fill_level<DEPTH.
  - Because of this rule, a push never hits a full FIFO.
- FIFO:
  - instr, instr_addr and instr_valid are driven combinationally from the head entry.
  - Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle: fill_level is unchanged.
  - Pop while empty is ignored.
- Redirect (highest priority):
  - Sampled in any state. On that edge:
    - the FIFO is flushed (fill_level=0, instr_valid=0 the next cycle);
    - fetch_addr is set to redirect_addr;
    - the FSM goes to GAP with spi_cs=1 and spi_sck=0;
    - any partially received word is discarded.
  - A pop or push coinciding with redirect is ignored.
  - A redirect during GAP restarts the CS_GAP count.
- Latency: with default parameters, instr_valid first rises on the 97th clk edge after the edge that samples redirect. This is CS_GAP + 2*(8+SPI_ADDR_W+INSTR_W) = 1+96.
- Throughput: steady state is one word every 2*INSTR_W cycles (32 with defaults).
- Reset mid-transfer: reset overrides everything, restores the reset values and aborts the transfer with spi_cs=1.

Test Plan:
- Reset, then rst_n=1, with an SRAM model holding word[n]=0xA000+n and instr_ready=1 -> on the pins: CS falls after 1 cycle, then MOSI bits 0x03 and 0x000000. instr_valid first rises at edge 97 with instr=0xA000, instr_addr=0. Subsequent words follow every 32 cycles.
- instr_ready=0 -> fill_level climbs to 4, then spi_sck stops with spi_cs=0 (PAUSE). One pop -> fill_level=3, streaming resumes, instr_addr=4 is delivered next.
- Redirect to 0x0100 while a word is mid-DATA -> the next cycle has instr_valid=0 and spi_cs=1. MOSI then sends 0x03, 0x000200. The first instr is 0xA100 with instr_addr=0x0100. The partial word never appears.
- Redirect and pop in the same cycle with a full FIFO -> fill_level=0 next cycle, and no pop side effects.
- Start at redirect_addr=0xFFFE -> instr_addr sequence 0xFFFE, 0xFFFF, 0x0000 with a single CS assertion.
- Assert rst_n=0 mid-ADDR -> the next cycle shows spi_cs=1, spi_sck=0, fill_level=0. The fetch restarts at RESET_ADDR after release.
